updown_counter_p: RTL
=====================

# updown_counter_p

Parametrised up/down event counter, successor to the fixed 8-bit PED-driven counter used with the TramelBlaze processor. It accepts a raw, externally debounced pulse input and synchronises and edge-detects it internally. Each detected edge counts up or down by a configurable step within a programmable modulus, with wrap or saturate behaviour. It also provides parallel load and sticky overflow/underflow flags that the processor can poll through a port.

## Interface
Parameters:
- WIDTH, 8, counter width in bits (2..32)
- MAX_COUNT, 2**WIDTH-1, terminal value; count range is 0..MAX_COUNT
- STEP, 1, increment/decrement magnitude (1..MAX_COUNT)
- SAT, 0, 0 = wrap modulo MAX_COUNT+1; 1 = saturate at 0/MAX_COUNT
- SYNC_STAGES, 2, synchroniser depth for btn (>=2)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- btn  in  1  raw asynchronous pulse input, already debounced
- uphdnl  in  1  1 = count up, 0 = count down; sampled on the event cycle
- enable  in  1  1 = detected edges modify count
- load  in  1  parallel load strobe
- load_val  in  WIDTH  load value
- clr_flags  in  1  clears ovf/unf
- count  out  WIDTH  current count, registered
- ped_out  out  1  one-cycle pulse per detected btn rising edge
- at_max  out  1  count == MAX_COUNT (combinational from count)
- at_min  out  1  count == 0 (combinational from count)
- ovf  out  1  sticky: an up step crossed MAX_COUNT
- unf  out  1  sticky: a down step crossed 0

## Operation
- Synchroniser: btn passes through a SYNC_STAGES flop chain s[0..N-1]. A further flop s_d holds the previous s[N-1].
- Edge detect: ped = s[N-1] & ~s_d, combinational, driven on ped_out.
- Event: ev = ped & enable. With enable=0, ped_out still pulses and count holds.
- Priority per cycle: reset > load > ev > hold.
- Load: count <= min(load_val, MAX_COUNT). A coincident ev is discarded. Flags are unaffected.
- Up event: arithmetic is in WIDTH+1 bits, sum = count + STEP.
  - If sum <= MAX_COUNT: count <= sum.
  - Otherwise ovf <= 1, and count <= sum - (MAX_COUNT+1) when SAT=0, or count <= MAX_COUNT when SAT=1.
- Down event:
  - If count >= STEP: count <= count - STEP.
  - Otherwise unf <= 1, and count <= count + (MAX_COUNT+1) - STEP when SAT=0, or count <= 0 when SAT=1.
- Saturate mode: a step already at the limit leaves count unchanged but still sets the flag.
- Flags: clr_flags clears both ovf and unf. If clr_flags and a flag-setting event occur in the same cycle, set wins.
- Reset: count=0, ovf=0, unf=0, s[*]=0, s_d=0. Hence ped_out=0, at_min=1, and at_max=0 (MAX_COUNT>0).
- btn held high through reset produces exactly one event after reset release.

## Timing
- Let edge k be the first rising edge at which s[0] captures btn=1.
  - ped_out is high for exactly the cycle following edge k+SYNC_STAGES-1.
  - count updates on edge k+SYNC_STAGES.
- Total btn-to-count latency is SYNC_STAGES clocks, plus up to 1 clock of sampling uncertainty.
- btn must be high >=1 clk and low >=1 clk between edges for every edge to count. Shorter pulses may be lost and are not flagged.
- load takes effect on the next edge, with 1-cycle latency, regardless of the sync pipeline.
- at_max/at_min follow count in the same cycle. ovf/unf assert on the same edge as the offending count update.
- reset asserted mid-pipeline flushes any in-flight edge: no event after release unless btn is still high.

## Test plan
- Reset and basic up (WIDTH=8, defaults): assert reset for 2 clk, then pulse btn 3 times with uphdnl=1. Expect count 0→3, each update SYNC_STAGES clocks after capture, and ped_out high 1 cycle per pulse.
- Wrap (MAX_COUNT=9, SAT=0, STEP=1):
  - Load 9, then 1 up event. Expect count=0, ovf=1, at_min=1.
  - Then 1 down event. Expect count=9, unf=1.
- Saturate with step (MAX_COUNT=9, SAT=1, STEP=3):
  - Load 8, then 1 up event. Expect count=9, ovf=1.
  - Load 2, then 1 down event. Expect count=0, unf=1.
- Priority and gating:
  - Apply load=1 with load_val=5 in the same cycle as ped. Expect count=5, ev dropped, flags unchanged.
  - With enable=0, pulse btn. Expect ped_out pulses and count holds.
  - Load 12 with MAX_COUNT=9. Expect count=9.
- Flag clear race: set ovf, then assert clr_flags alone. Expect ovf=0. Then assert clr_flags in the same cycle as an overflowing event. Expect ovf=1.
- Reset mid-operation: raise btn, assert reset 1 cycle later for 1 clk while btn is held high. Expect count=0 after reset and exactly one event after release. Then assert reset during a short btn pulse. Expect no event.

Source files
------------

// File: rtl/updown_counter_p.sv
// Parametrised up/down event counter: synchronised, edge-detected pulse input,
// modulus wrap or saturate, parallel load and sticky overflow/underflow flags.
module updown_counter_p #(
  parameter int unsigned             WIDTH       = 8,
  parameter logic [WIDTH-1:0]        MAX_COUNT   = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0]        STEP        = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter bit                      SAT         = 1'b0,
  parameter int unsigned             SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn,
  input  logic             uphdnl,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] count,
  output logic             ped_out,
  output logic             at_max,
  output logic             at_min,
  output logic             ovf,
  output logic             unf
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] s;
  logic                   s_d;
  logic                   ped;
  logic                   ev;

  logic [WIDTH:0]         sum;
  logic [WIDTH-1:0]       wrap_up;
  logic [WIDTH-1:0]       wrap_dn;
  logic [WIDTH-1:0]       load_clip;
  logic [WIDTH-1:0]       count_n;
  logic                   ovf_set;
  logic                   unf_set;

  assign ped     = s[SYNC_STAGES-1] & ~s_d;
  assign ev      = ped & enable;
  assign ped_out = ped;
  assign at_max  = (count == MAX_COUNT);
  assign at_min  = (count == '0);

  // Wrapped results fit in WIDTH bits, so the modulus subtraction is done
  // modulo 2**WIDTH: -(MAX_COUNT+1) == ~MAX_COUNT in two's complement.
  assign sum     = {1'b0, count} + {1'b0, STEP};
  assign wrap_up = count + STEP + ~MAX_COUNT;
  assign wrap_dn = count - STEP + MAX_COUNT + ONE;
  assign load_clip = (load_val > MAX_COUNT) ? MAX_COUNT : load_val;

  always_comb begin
    count_n = count;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (load) begin
      count_n = load_clip;
    end else if (ev) begin
      if (uphdnl) begin
        if (sum <= {1'b0, MAX_COUNT}) begin
          count_n = sum[WIDTH-1:0];
        end else begin
          ovf_set = 1'b1;
          count_n = SAT ? MAX_COUNT : wrap_up;
        end
      end else begin
        if (count >= STEP) begin
          count_n = count - STEP;
        end else begin
          unf_set = 1'b1;
          count_n = SAT ? '0 : wrap_dn;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s     <= '0;
      s_d   <= 1'b0;
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      if (SYNC_STAGES > 1) begin
        s <= {s[SYNC_STAGES-2:0], btn};
      end else begin
        s <= btn;
      end
      s_d   <= s[SYNC_STAGES-1];
      count <= count_n;
      // A flag being set in the same cycle as clr_flags keeps the flag.
      ovf   <= ovf_set | (ovf & ~clr_flags);
      unf   <= unf_set | (unf & ~clr_flags);
    end
  end

endmodule
